display_scheduler: RTL
======================

# display_scheduler

Time-shares the 8-digit seven-segment display between up to `N_REQ` requesters and generates the scan timing for the display path. It sits in front of the temporal digit mux, anode decoder and BCD-to-segment decoder. It chooses which requester's 32-bit word is shown, keeps that word stable for whole refresh frames, and drives the digit-scan index. This replaces the free-running scan counter.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `PRESCALE`, 100000: clock cycles per digit step (≥2).
- `HOLD_FRAMES`, 64: minimum frames an owner keeps the display while others wait (≥1).

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  `N_REQ`  per-requester display request, level-sensitive.
- `value`  in  `32*N_REQ`  packed words; requester i at `[32i+31:32i]`, 8 hex nibbles, nibble k = digit k.
- `grant`  out  `N_REQ`  one-hot current owner; all-zero when idle.
- `HEX_out`  out  32  word to display, to the temporal mux.
- `digit_sel`  out  3  active digit index, to the mux and anode decoder.
- `blank`  out  1  high when no owner; downstream forces all anodes off.
- `frame_done`  out  1  one-cycle pulse at each frame end.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `tick` is asserted while `pcnt == PRESCALE-1`.
- `digit_sel` increments on each tick and wraps 7→0. `frame_done` = tick AND `digit_sel == 7`, a combinational pulse in the same cycle as the 7→0 wrap edge.
- Round-robin pointer `last` holds the index of the most recent owner. Search order is `last+1, last+2, …` modulo `N_REQ`. The first asserted `req` wins.
- FSM has two states, IDLE and OWN:
  - IDLE: `grant=0`, `blank=1`, `HEX_out` holds its last value. If any `req` is high, the next edge moves to OWN. On that edge the winner's bit is set in `grant`, `last` := winner, `HEX_out` := `value[winner]`, and `hold` := 0. The grant does not wait for a frame boundary.
  - OWN: `blank=0`. On each `frame_done` edge, `HEX_out` is reloaded from the owner's `value`, and `hold` increments, saturating at HOLD_FRAMES. `HEX_out` never changes mid-frame.
  - OWN, decision on a `frame_done` edge, first match applies:
    1. Owner's `req` is low and another request is pending: grant the round-robin winner, `hold` := 0.
    2. Owner's `req` is low and nothing is pending: go to IDLE, `grant` := 0.
    3. Owner's `req` is high, `hold+1 ≥ HOLD_FRAMES`, and another requester is pending: rotate to the round-robin winner, `hold` := 0.
    4. Otherwise: keep the owner.
  - Between frame boundaries the FSM never changes `grant`, even if the owner drops `req`.
- When the owner is the only requester it keeps the display indefinitely. `hold` saturates and does not wrap.
- `req` bits at or above `N_REQ` do not exist. Out-of-range indices are never produced.

## Timing
- Reset values: `pcnt=0`, `digit_sel=0`, `frame_done=0`, `grant=0`, `blank=1`, `HEX_out=0`, `hold=0`, `last=N_REQ-1` (requester 0 wins first), state IDLE.
- Reset takes priority over every other event. Asserting it mid-frame or mid-ownership restores all reset values on that edge.
- Frame length is exactly `8*PRESCALE` cycles. The first `frame_done` after reset release occurs at cycle `8*PRESCALE-1`.
- Request latency from IDLE: `req` sampled high at edge n gives `grant`/`HEX_out` valid after edge n, which is 1 cycle.
- Release or rotation takes effect on the `frame_done` edge, so latency is ≤ `8*PRESCALE` cycles after the condition becomes true.
- Scan counting never stops. `digit_sel` advances in IDLE too.
- `grant` and `HEX_out` change only on the same edge as a state or owner change, or on a `frame_done` reload.

## Test plan
Bench parameters: `N_REQ=4`, `PRESCALE=4`, `HOLD_FRAMES=2`, giving a frame of 32 cycles.
1. Reset, then hold `reset=0` for 3 cycles → `grant=0`, `blank=1`, `HEX_out=0`, `digit_sel=0`. After release, `digit_sel` steps every 4 cycles, and `frame_done` pulses at cycles 31, 63, ….
2. Assert only `req[2]` with `value[2]=32'h1234_5678` → one cycle later `grant=4'b0100`, `blank=0`, `HEX_out=32'h12345678`. Change `value[2]` mid-frame → `HEX_out` updates only at the next `frame_done` edge.
3. Assert `req=4'b1111` from IDLE after reset → grant order is 0,1,2,3,0. Each owner holds exactly 2 frames (64 cycles), and every switch occurs on a `frame_done` edge.
4. Owner 0 holds; at frame 0 assert `req[1]`, and at frame 0 mid-way drop `req[0]` → ownership passes to 1 at the first frame boundary, not waiting for `HOLD_FRAMES`.
5. Sole owner 3 drops `req` with no others pending → at the next `frame_done` edge `grant=0` and `blank=1`. `HEX_out` retains its last word.
6. Apply reset mid-frame while owner 1 is active → all reset values appear on that edge. Re-requesting `req=4'b0110` afterwards grants 1 first, since `last=3` and the search starts at 0.

Source files
------------

// File: rtl/display_scheduler_if.sv
// Display scheduler bus: requester words in, the chosen word and scan timing out.
interface display_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0][31:0] value;
    logic [N_REQ-1:0]       grant;
    logic [31:0]            HEX_out;
    logic [2:0]             digit_sel;
    logic                   blank;
    logic                   frame_done;

    // master = requester/display side, slave = scheduler
    modport master (
        output req, value,
        input  grant, HEX_out, digit_sel, blank, frame_done
    );
    modport slave (
        input  req, value,
        output grant, HEX_out, digit_sel, blank, frame_done
    );
endinterface

// File: rtl/display_scheduler.sv
// Time-shares the 8-digit display between N_REQ requesters with round-robin
// ownership that only changes on frame boundaries, and drives the digit scan.
module display_scheduler #(
    parameter int N_REQ       = 4,
    parameter int PRESCALE    = 100000,
    parameter int HOLD_FRAMES = 64
) (
    input  logic               clock,
    input  logic               reset,
    display_scheduler_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state;
    logic [PW-1:0]    pcnt;
    logic [2:0]       digit_sel;
    logic             tick;
    logic             frame_done;
    logic [IW-1:0]    last;       // in OWN this is also the current owner
    logic [HW-1:0]    hold;
    logic [N_REQ-1:0] grant;
    logic [31:0]      hex_word;
    logic             blank;

    logic             rr_hit;
    logic [IW-1:0]    rr_idx;
    logic [IW-1:0]    cand;
    logic [IW:0]      sum;
    logic [N_REQ-1:0] rr_onehot;
    logic             other_pending;
    logic             owner_req;
    logic             hold_done;

    assign tick       = (pcnt == PW'(PRESCALE - 1));
    assign frame_done = tick && (digit_sel == 3'd7);

    // Free-running prescaler and digit scan; never stops, even when idle
    always_ff @(posedge clock) begin
        if (!reset) begin
            pcnt      <= '0;
            digit_sel <= '0;
        end else if (tick) begin
            pcnt      <= '0;
            digit_sel <= digit_sel + 3'd1;
        end else begin
            pcnt      <= pcnt + PW'(1);
        end
    end

    // Round-robin search starting just after the last owner; last owner is checked last
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = last;
        cand   = '0;
        sum    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, last} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ))
                sum = sum - (IW+1)'(N_REQ);
            cand = sum[IW-1:0];
            if (!rr_hit && bus.req[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    // One-hot form of the search winner, loaded into grant on a handover
    always_comb begin
        rr_onehot         = '0;
        rr_onehot[rr_idx] = 1'b1;
    end

    // Because the owner is checked last, a winner other than the owner means
    // someone else is waiting.
    assign other_pending = rr_hit && (rr_idx != last);
    assign owner_req     = bus.req[last];
    assign hold_done     = ((HW+1)'(hold) + (HW+1)'(1)) >= (HW+1)'(HOLD_FRAMES);

    // Ownership FSM: immediate grant from idle, all other decisions on frame_done
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            blank    <= 1'b1;
            hex_word <= '0;
            hold     <= '0;
            last     <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (rr_hit) begin
                        state    <= OWN;
                        grant    <= rr_onehot;
                        blank    <= 1'b0;
                        last     <= rr_idx;
                        hex_word <= bus.value[rr_idx];
                        hold     <= '0;
                    end
                end
                OWN: begin
                    if (frame_done) begin
                        if ((!owner_req || hold_done) && other_pending) begin
                            // owner gone, or served long enough while others wait
                            grant    <= rr_onehot;
                            last     <= rr_idx;
                            hex_word <= bus.value[rr_idx];
                            hold     <= '0;
                        end else if (!owner_req) begin
                            // nobody left: blank, keep the last word on HEX_out
                            state    <= IDLE;
                            grant    <= '0;
                            blank    <= 1'b1;
                        end else begin
                            hex_word <= bus.value[last];
                            if (hold != HW'(HOLD_FRAMES))
                                hold <= hold + HW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant      = grant;
    assign bus.HEX_out    = hex_word;
    assign bus.digit_sel  = digit_sel;
    assign bus.blank      = blank;
    assign bus.frame_done = frame_done;

endmodule
